// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: state encoding, key map and
// column rotation reset value.
package keypad_pkg;

    typedef logic [1:0] kpd_state_t;

    localparam kpd_state_t ST_SCAN     = 2'd0;
    localparam kpd_state_t ST_DEBOUNCE = 2'd1;
    localparam kpd_state_t ST_PRESSED  = 2'd2;
    localparam kpd_state_t ST_RELEASE  = 2'd3;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Nibble {row, col} holds the key code; row0 is 1,2,3,A ... row3 is 0,F,E,D.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic [9:0] digit_onehot_of(input logic [3:0] code);
        return (code <= 4'd9) ? (10'd1 << code) : 10'd0;
    endfunction

endpackage

// File: rtl/kpd_scan_timer.sv
// Free-running dwell counter; tick_o marks the terminal count of each column
// dwell period.
module kpd_scan_timer #(
    parameter int unsigned SCAN_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SCAN_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces a
// single pressed key and reports it once per physical press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES      = 100000,
    parameter int unsigned DEBOUNCE_SAMPLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [9:0] digit_onehot,
    output logic       key_held
);

    localparam int unsigned DebW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES + 1) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_SAMPLES - 1);
    localparam bit SingleSample = (DEBOUNCE_SAMPLES <= 1);

    logic [3:0] row_s1_q, row_s2_q;
    kpd_state_t state_q, state_d;
    logic [3:0] col_q, col_d, col_rot;
    logic [3:0] row_pat_q, row_pat_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic [9:0] onehot_q, onehot_d;
    logic       tick, one_low, all_high, accept;
    logic [1:0] row_idx, col_idx;

    kpd_scan_timer #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick_o(tick)
    );

    assign col_rot  = {col_q[2:0], col_q[3]};
    assign all_high = (row_s2_q == 4'b1111);

    always_comb begin
        one_low = 1'b1;
        case (row_s2_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    end

    // Row index comes from the latched pattern, which equals the live sample on accept.
    always_comb begin
        row_idx = 2'd0;
        case (row_pat_d)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_pat_d   = row_pat_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        onehot_d    = '0;
        accept      = 1'b0;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_low) begin
                        row_pat_d = row_s2_q;
                        deb_cnt_d = DebW'(1);
                        if (SingleSample) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s2_q == row_pat_q) begin
                        if (deb_cnt_q == DebLast) begin
                            accept = 1'b1;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_d     = col_rot;
                        deb_cnt_d = '0;
                    end
                end
                ST_PRESSED: begin
                    if (all_high) begin
                        if (SingleSample) begin
                            state_d = ST_SCAN;
                            col_d   = col_rot;
                        end else begin
                            state_d   = ST_RELEASE;
                            rel_cnt_d = DebW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!all_high) begin
                        state_d   = ST_PRESSED;
                        rel_cnt_d = '0;
                    end else if (rel_cnt_q == DebLast) begin
                        state_d   = ST_SCAN;
                        col_d     = col_rot;
                        rel_cnt_d = '0;
                    end else begin
                        rel_cnt_d = rel_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        if (accept) begin
            state_d     = ST_PRESSED;
            deb_cnt_d   = '0;
            key_valid_d = 1'b1;
            key_code_d  = key_lookup(row_idx, col_idx);
            onehot_d    = digit_onehot_of(key_code_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            state_q     <= ST_SCAN;
            col_q       <= COL_RESET;
            row_pat_q   <= 4'b1111;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            onehot_q    <= '0;
        end else begin
            row_s1_q    <= row_in;
            row_s2_q    <= row_s1_q;
            state_q     <= state_d;
            col_q       <= col_d;
            row_pat_q   <= row_pat_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            onehot_q    <= onehot_d;
        end
    end

    assign col_out      = col_q;
    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign digit_onehot = onehot_q;
    assign key_held     = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_SAMPLES=3;
// a keypad model pulls rows low when a pressed key's column is driven.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic [9:0] digit_onehot;
    logic       key_held;

    logic [15:0] key_mask;  // bit row*4+col set = key pressed
    logic [3:0]  cols [4];

    int tests  = 0;
    int fails  = 0;
    int k      = 0;
    int kv_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_SAMPLES(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .digit_onehot(digit_onehot),
        .key_held    (key_held)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (key_valid === 1'b1) kv_cnt++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        cols[0] = 4'b1110;
        cols[1] = 4'b1101;
        cols[2] = 4'b1011;
        cols[3] = 4'b0111;
        rst = 1'b1;
        key_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col_out), 32'h0000000e);
        check("rst_kv", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_onehot", 32'(digit_onehot), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;
        k = 0;

        // Idle: 20 ticks of rotation, 4 clocks per column.
        for (int i = 0; i < 80; i++) begin
            check("idle_col", 32'(col_out), 32'(cols[(k/4)%4]));
            step();
        end
        check("idle_kv_cnt", 32'(kv_cnt), 32'd0);

        // Key 6 (row1/col2): latched at tick 91, accepted on tick 99.
        key_mask = 16'h0040;
        run_to(99);
        check("k6_kv_early", 32'(key_valid), 32'd0);
        check("k6_col_frozen", 32'(col_out), 32'h0000000b);
        step();
        check("k6_kv", 32'(key_valid), 32'd1);
        check("k6_code", 32'(key_code), 32'd6);
        check("k6_onehot", 32'(digit_onehot), 32'h00000040);
        check("k6_held", 32'(key_held), 32'd1);
        step();
        check("k6_kv_pulse", 32'(key_valid), 32'd0);
        check("k6_onehot_pulse", 32'(digit_onehot), 32'd0);
        check("k6_code_hold", 32'(key_code), 32'd6);
        run_to(120);
        check("k6_held_long", 32'(key_held), 32'd1);
        check("k6_kv_once", 32'(kv_cnt), 32'd1);
        key_mask = '0;
        run_to(131);
        check("k6_held_rel", 32'(key_held), 32'd1);
        step();
        check("k6_released", 32'(key_held), 32'd0);
        check("k6_col_adv", 32'(col_out), 32'h00000007);

        // Key A pressed for two samples only: no acceptance.
        key_mask = 16'h0008;
        run_to(140);
        key_mask = '0;
        check("ka_col_frozen", 32'(col_out), 32'h00000007);
        run_to(144);
        check("ka_col_adv", 32'(col_out), 32'h0000000e);
        check("ka_held", 32'(key_held), 32'd0);
        check("ka_no_kv", 32'(kv_cnt), 32'd1);

        // Keys 2 and 8 together in col1: ignored, scanning continues.
        key_mask = 16'h0202;
        run_to(152);
        check("dbl_col_adv", 32'(col_out), 32'h0000000b);
        run_to(168);
        check("dbl_col_cont", 32'(col_out), 32'h0000000b);
        check("dbl_held", 32'(key_held), 32'd0);
        check("dbl_no_kv", 32'(kv_cnt), 32'd1);

        // Key 0 held long, with a one-sample bounce during release.
        key_mask = 16'h1000;
        run_to(187);
        check("k0_kv_early", 32'(key_valid), 32'd0);
        check("k0_code_prev", 32'(key_code), 32'd6);
        step();
        check("k0_kv", 32'(key_valid), 32'd1);
        check("k0_code", 32'(key_code), 32'd0);
        check("k0_onehot", 32'(digit_onehot), 32'h00000001);
        run_to(400);
        check("k0_kv_once", 32'(kv_cnt), 32'd2);
        check("k0_held", 32'(key_held), 32'd1);
        check("k0_col", 32'(col_out), 32'h0000000e);
        key_mask = '0;
        run_to(408);
        key_mask = 16'h1000;
        run_to(412);
        key_mask = '0;
        check("k0_bounce_held", 32'(key_held), 32'd1);
        run_to(420);
        check("k0_held_rel2", 32'(key_held), 32'd1);
        run_to(423);
        check("k0_held_rel3", 32'(key_held), 32'd1);
        step();
        check("k0_released", 32'(key_held), 32'd0);
        check("k0_col_adv", 32'(col_out), 32'h0000000d);
        check("k0_kv_total", 32'(kv_cnt), 32'd2);

        // Key 5 in debounce when reset hits; reported once afterwards.
        key_mask = 16'h0020;
        run_to(432);
        check("k5_col_frozen", 32'(col_out), 32'h0000000d);
        rst = 1'b1;
        step();
        check("k5_rst_col", 32'(col_out), 32'h0000000e);
        check("k5_rst_kv", 32'(key_valid), 32'd0);
        check("k5_rst_code", 32'(key_code), 32'd0);
        check("k5_rst_onehot", 32'(digit_onehot), 32'd0);
        check("k5_rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;
        run_to(448);
        check("k5_kv_early", 32'(key_valid), 32'd0);
        check("k5_no_kv_yet", 32'(kv_cnt), 32'd2);
        step();
        check("k5_kv", 32'(key_valid), 32'd1);
        check("k5_code", 32'(key_code), 32'd5);
        check("k5_onehot", 32'(digit_onehot), 32'h00000020);
        check("k5_held", 32'(key_held), 32'd1);
        run_to(470);
        check("k5_kv_once", 32'(kv_cnt), 32'd3);
        key_mask = '0;
        run_to(500);
        check("k5_released", 32'(key_held), 32'd0);
        check("final_kv_total", 32'(kv_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
